pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Fetch-stage controller that owns the architectural PC register. It closes the loop with the PC+4 adder: it drives the current `pc` out to the adder and consumes the returned `npc`, or a branch target on redirect. It issues one outstanding instruction-memory request at a time and buffers the returned instruction for the decode stage behind a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h1C00_0000: PC value loaded on reset.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc` out 32: current fetch PC; feeds the PC+4 adder.
- `npc` in 32: `pc + 4` returned from the adder.
- `br_taken` in 1: redirect request from execute; one-cycle pulse.
- `br_target` in 32: redirect PC; valid when `br_taken`=1.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: buffered instruction available to decode.
- `if_pc` out 32: PC of the buffered instruction.
- `if_inst` out 32: buffered instruction.
- `id_ready` in 1: decode accepts the buffered instruction this cycle.

## Operation
- The block uses four states: IDLE, REQ, WAIT and HOLD. It also holds a 1-bit `kill` flag.
- Reset (any state): state=IDLE, `pc`=RESET_PC, `kill`=0, `if_valid`=0, `if_pc`=0, `if_inst`=0.
  - `imem_req` is 0 while in IDLE.
- Combinational outputs: `imem_req` = (state==REQ), `imem_addr` = `pc`.
- IDLE: always goes to REQ next cycle. `br_taken` is ignored in IDLE.
- REQ:
  - `imem_gnt`=1: go to WAIT.
  - `br_taken`=1 without grant: `pc`<=`br_target`; stay in REQ. The new address is presented next cycle.
  - `br_taken`=1 with grant: `pc`<=`br_target`, `kill`<=1, go to WAIT.
- WAIT:
  - `imem_rvalid`=1, `kill`=0 and `br_taken`=0: `if_inst`<=`imem_rdata`, `if_pc`<=`pc`, `pc`<=`npc`, `if_valid`<=1, go to HOLD.
  - `imem_rvalid`=1 with `kill`=1 or `br_taken`=1: discard the data and set `kill`<=0. If `br_taken`=1, also `pc`<=`br_target`. Go to REQ.
  - `imem_rvalid`=0 with `br_taken`=1: `pc`<=`br_target`, `kill`<=1, stay in WAIT.
- HOLD:
  - `br_taken`=1 has priority over `id_ready`: `if_valid`<=0 (flush), `pc`<=`br_target`, go to REQ.
  - Otherwise `id_ready`=1: `if_valid`<=0, go to REQ.
  - Otherwise hold. `if_pc` and `if_inst` stay stable while `if_valid`=1.
- `imem_rvalid` outside WAIT is ignored, including stale responses after reset.
- `imem_gnt` outside REQ is ignored.
- PC arithmetic belongs to the adder. This block never adds; `npc` wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- At most one request is outstanding. `imem_req` never rises while in WAIT.

## Timing
- Reset is released at edge E1 (first edge with `rst`=0): IDLE→REQ, so `imem_req`=1 during cycle E1–E2.
- With zero-wait memory (grant in the request cycle, `imem_rvalid` the following cycle), `if_valid`=1 after edge E3.
  - Latency is 3 cycles from reset release to the first instruction visible.
- Steady-state throughput with zero-wait memory and `id_ready` held at 1 is one instruction per 3 cycles (REQ, WAIT, HOLD).
- A redirect in HOLD puts the new `pc` on `imem_addr` in the next cycle.
- A redirect in WAIT costs one discarded response plus a fresh REQ.
- `rst` asserted in any cycle overrides every other input at that edge.

## Test plan
- Reset, then zero-wait memory returning 0x0000_0013 at every address, with `id_ready`=1:
  - `imem_addr` sequence 0x1C00_0000, 0x1C00_0004, 0x1C00_0008.
  - `if_valid` first high 3 cycles after reset release.
  - `if_pc` tracks each fetched address.
- `imem_gnt` held low for 4 cycles in REQ → `imem_req` stays high, `imem_addr` stable, no state change.
- `id_ready`=0 for 5 cycles in HOLD → `if_valid`, `if_pc` and `if_inst` stable.
  - No new `imem_req` is issued until the handshake completes.
- `br_taken` with `br_target`=0x1C00_0100 while in WAIT, with `imem_rvalid` 2 cycles later carrying 0xDEAD_BEEF:
  - The response is discarded and `if_valid` stays 0.
  - Next `imem_addr`=0x1C00_0100.
- `br_taken` and `id_ready` together in HOLD → instruction flushed (`if_valid` 0 next cycle), next `imem_addr`=`br_target`.
- `rst` pulsed in WAIT with `imem_rvalid` arriving in IDLE/REQ → response ignored, fetch restarts at RESET_PC.
- RESET_PC=32'hFFFF_FFFC → second fetch address 0x0000_0000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the architectural PC, issues one instruction
// memory request at a time and buffers the returned word for decode.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] npc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
        end
    end

    // kill marks an in-flight response whose fetch was overtaken by a redirect;
    // that response must still be drained before the next request goes out.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (br_taken) begin
                    pc_d = br_target;
                end
                if (imem_gnt) begin
                    state_d = S_WAIT;
                    kill_d  = br_taken;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (!kill_q && !br_taken) begin
                        if_inst_d  = imem_rdata;
                        if_pc_d    = pc_q;
                        pc_d       = npc;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        if (br_taken) begin
                            pc_d = br_target;
                        end
                    end
                end else if (br_taken) begin
                    pc_d   = br_target;
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                // Decode handshake: the word transfers on a cycle with if_valid
                // and id_ready both high; a redirect flushes it instead.
                if (br_taken) begin
                    if_valid_d = 1'b0;
                    pc_d       = br_target;
                    state_d    = S_REQ;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc        = pc_q;
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule
